tile_skew_feeder: RTL and testbench
===================================

Name: tile_skew_feeder

Overview:
Front-end producer for the 8x8 systolic transpose array. Accepts a tile one row per handshake (LANES lanes x WIDTH bits). Replays the buffered tile onto the array's x lanes with a diagonal skew: lane i is delayed i cycles. Generates the array's start, per-lane clear and per-column shift controls, then signals tile completion.

Parameters:
LANES, 8, lanes per row and rows per tile.
WIDTH, 32, bits per element.
DRAIN_CYC, 8, cycles shift is held high after issue.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (0 = reset)
enable  input  1  global advance; 0 freezes all state and registered outputs
in_data  input  LANES*WIDTH  row; lane i at bits [i*WIDTH +: WIDTH]
in_valid  input  1  row valid
in_ready  output  1  row accepted when in_valid && in_ready at clk edge
x_out  output  LANES*WIDTH  skewed lane data to the array; same lane packing
x_valid  output  LANES  lane i carries a real element
start  output  1  high for every ISSUE beat
clear_out  output  LANES  1-cycle pulse on lane i when that lane emits row 0
shift  output  LANES  all-ones during DRAIN, else 0
busy  output  1  state != FILL
tile_done  output  1  1-cycle pulse on the last DRAIN cycle

Behaviour:
- Reset, asynchronous on reset=0: state=FILL; row_cnt=0, beat=0, drain_cnt=0. x_out=0, x_valid=0, start=0, clear_out=0, shift=0, tile_done=0. Buffer contents are don't-care.
- in_ready is combinational: enable && (buffer slot free). Non-pingpong: a slot is free only when state==FILL.
- in_valid without in_ready: ignored, no state change.
- FILL: each accepted row is written to buf[row_cnt], then row_cnt++. When the accept makes row_cnt reach LANES: row_cnt<=0, next state ISSUE, beat<=0.
- ISSUE: lasts LANES+LANES-1 beats (15 at default). At beat c, lane i computes r=c-i.
  - If 0<=r<LANES: x_out lane i = buf[r][i] and x_valid[i]=1.
  - Otherwise: lane data = 0 and x_valid[i]=0.
  - clear_out[i] = (r==0). start=1.
- At the last ISSUE beat, next state is DRAIN with drain_cnt<=0.
- DRAIN: lasts DRAIN_CYC cycles. shift=all-ones, start=0, x_valid=0, x_out=0. tile_done=1 on drain_cnt==DRAIN_CYC-1, then next state is FILL.
- All array-side outputs are registered. Beat c computed in cycle c of ISSUE appears on the outputs after the next edge, so the first lane-0 element appears 1 cycle after ISSUE is entered.
- enable=0: counters, state and outputs hold their current values (no bubble insertion); in_ready=0.
- Reset mid-ISSUE or mid-DRAIN: partial tile discarded, outputs 0 immediately, back to FILL.
- Widths: row_cnt and beat use clog2(2*LANES) bits. drain_cnt uses clog2(DRAIN_CYC)+1 bits. No wrap beyond the terminal values.

Optional Feature:
TILE_SKEW_FEEDER_PINGPONG_EN
- Defined:
  - Two tile buffers. FILL of buffer B runs concurrently with ISSUE/DRAIN of buffer A.
  - in_ready=enable && the fill buffer is not yet complete.
  - After DRAIN, if the other buffer is full, go directly to ISSUE with no FILL cycle and swap buffers. Otherwise go to FILL.
  - busy = ISSUE||DRAIN.
  - Simultaneous events (fill completing in the same cycle DRAIN ends) proceed directly to ISSUE.
- Undefined: single buffer; in_ready is low throughout ISSUE and DRAIN.

Test Plan:
- Reset then fill: load rows r=0..7 with lane i value 32'h0000_0r0i.
  - Expect in_ready=1 for 8 accepts, then 0, busy=1.
  - First ISSUE output: lane0=0x00000000, x_valid=8'h01, clear_out=8'h01.
- Skew check: at ISSUE beat 5 expect lane3=0x00000203, lane5=0x00000005, lane6 x_valid=0. At beat 14 expect x_valid=8'h80, lane7=0x00000707.
- Drain: 8 cycles shift=8'hFF after the last beat. tile_done is high only on cycle 8. Next cycle state=FILL, in_ready=1.
- Stall: deassert enable for 3 cycles at ISSUE beat 4.
  - Outputs hold beat-4 values and in_ready=0.
  - Resuming yields beat 5 with no skipped or duplicated beat.
- Async reset: pull reset=0 between edges at DRAIN cycle 3.
  - All outputs 0 immediately.
  - After release, a new tile of 8 rows is accepted and issued correctly.
- PINGPONG_EN: stream 16 rows back-to-back with in_valid=1.
  - in_ready stays 1 throughout ISSUE of tile 0 until tile 1 is full.
  - Tile 1 ISSUE starts the cycle after tile 0's tile_done.

Source files
------------

// File: rtl/tile_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tile_skew_feeder
// Brief    : Buffers an LANES x LANES tile one row per handshake and replays
//            it onto the systolic array x lanes with a diagonal skew (lane i
//            delayed i cycles), driving start / clear / shift / tile_done.
// Options  : TILE_SKEW_FEEDER_PINGPONG_EN - two tile buffers so the next tile
//            fills while the current one issues and drains.
// Revision : 1.0 - initial release
// ============================================================================
module tile_skew_feeder #(
  parameter int LANES     = 8,
  parameter int WIDTH     = 32,
  parameter int DRAIN_CYC = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] x_out,
  output logic [LANES-1:0]       x_valid,
  output logic                   start,
  output logic [LANES-1:0]       clear_out,
  output logic [LANES-1:0]       shift,
  output logic                   busy,
  output logic                   tile_done
);

  localparam int CW = $clog2(2*LANES);
  localparam int DW = $clog2(DRAIN_CYC) + 1;
  localparam int RW = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef TILE_SKEW_FEEDER_PINGPONG_EN
  localparam int NBUF = 2;
  localparam int AW   = RW + 1;
`else
  localparam int NBUF = 1;
  localparam int AW   = RW;
`endif

  localparam logic [CW-1:0] ROW_LAST   = CW'(LANES - 1);
  localparam logic [CW-1:0] BEAT_LAST  = CW'(2*LANES - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    row_cnt;
  logic [CW-1:0]    beat;
  logic [DW-1:0]    drain_cnt;
  logic [WIDTH-1:0] tile_mem [NBUF*LANES][LANES];

  logic             accept;
  logic             fill_last;
  logic             drain_end;
  logic             start_ready;
  logic [AW-1:0]    wr_row;

  logic [LANES*WIDTH-1:0] lane_data;
  logic [LANES-1:0]       lane_valid;
  logic [LANES-1:0]       lane_first;

  logic [LANES*WIDTH-1:0] x_out_nxt;
  logic [LANES-1:0]       x_valid_nxt;
  logic [LANES-1:0]       clear_nxt;
  logic [LANES-1:0]       shift_nxt;
  logic                   start_nxt;
  logic                   done_nxt;

  assign accept    = in_valid && in_ready;
  assign fill_last = accept && (row_cnt == ROW_LAST);
  assign drain_end = enable && (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign busy      = (state != ST_FILL);

`ifdef TILE_SKEW_FEEDER_PINGPONG_EN
  logic       fill_sel;
  logic       issue_sel;
  logic [1:0] full;
  logic       target;

  // While idle the next tile comes from issue_sel; while draining it is the other buffer.
  assign target      = (state == ST_FILL) ? issue_sel : ~issue_sel;
  assign start_ready = full[target] || (fill_last && (fill_sel == target));
  assign in_ready    = enable && !full[fill_sel];
  assign wr_row      = {fill_sel, row_cnt[RW-1:0]};

  // Buffer ownership: a completed fill marks its buffer full and moves filling
  // to the other one; finishing a drain releases the issued buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_sel  <= 1'b0;
      issue_sel <= 1'b0;
      full      <= 2'b00;
    end else if (enable) begin
      if (fill_last) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
      end
      if (drain_end) begin
        full[issue_sel] <= 1'b0;
        issue_sel       <= ~issue_sel;
      end
    end
  end
`else
  assign start_ready = fill_last;
  assign in_ready    = enable && (state == ST_FILL);
  assign wr_row      = row_cnt[RW-1:0];
`endif

  // Per-lane skew: lane i shows row (beat - i) while that row index is in range.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [CW-1:0] diff;
      logic          in_win;
      logic [AW-1:0] rd_row;
      assign diff   = beat - CW'(gi);
      assign in_win = (beat >= CW'(gi)) && (diff < CW'(LANES));
`ifdef TILE_SKEW_FEEDER_PINGPONG_EN
      assign rd_row = {issue_sel, diff[RW-1:0]};
`else
      assign rd_row = diff[RW-1:0];
`endif
      assign lane_valid[gi]               = in_win;
      assign lane_first[gi]               = in_win && (diff == '0);
      assign lane_data[gi*WIDTH +: WIDTH] = in_win ? tile_mem[rd_row][gi] : '0;
    end
  endgenerate

  // Tile storage: accepted rows land at the current fill row; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        tile_mem[wr_row][i] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Row, beat and drain counters; each returns to zero at its terminal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt   <= '0;
      beat      <= '0;
      drain_cnt <= '0;
    end else if (enable) begin
      if (accept) begin
        row_cnt <= fill_last ? '0 : row_cnt + 1'b1;
      end
      beat      <= ((state == ST_ISSUE) && (beat != BEAT_LAST)) ? beat + 1'b1 : '0;
      drain_cnt <= ((state == ST_DRAIN) && (drain_cnt != DRAIN_LAST)) ? drain_cnt + 1'b1 : '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; every transition is qualified by enable.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (start_ready) state_nxt = ST_ISSUE;
      ST_ISSUE: if (enable && (beat == BEAT_LAST)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_nxt = start_ready ? ST_ISSUE : ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // Array-side values for the current cycle, registered below.
  always_comb begin
    x_out_nxt   = '0;
    x_valid_nxt = '0;
    clear_nxt   = '0;
    shift_nxt   = '0;
    start_nxt   = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      ST_ISSUE: begin
        start_nxt   = 1'b1;
        x_out_nxt   = lane_data;
        x_valid_nxt = lane_valid;
        clear_nxt   = lane_first;
      end
      ST_DRAIN: begin
        shift_nxt = '1;
        done_nxt  = (drain_cnt == DRAIN_LAST);
      end
      default: ;
    endcase
  end

  // Output registers; enable low holds the last presented values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out     <= '0;
      x_valid   <= '0;
      clear_out <= '0;
      shift     <= '0;
      start     <= 1'b0;
      tile_done <= 1'b0;
    end else if (enable) begin
      x_out     <= x_out_nxt;
      x_valid   <= x_valid_nxt;
      clear_out <= clear_nxt;
      shift     <= shift_nxt;
      start     <= start_nxt;
      tile_done <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_skew_feeder
// Brief    : Directed self-checking bench for tile_skew_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_skew_feeder;

  localparam int LANES     = 8;
  localparam int WIDTH     = 32;
  localparam int DRAIN_CYC = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] x_out;
  logic [LANES-1:0]       x_valid;
  logic                   start;
  logic [LANES-1:0]       clear_out;
  logic [LANES-1:0]       shift;
  logic                   busy;
  logic                   tile_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tile_skew_feeder #(.LANES(LANES), .WIDTH(WIDTH), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .x_valid   (x_valid),
    .start     (start),
    .clear_out (clear_out),
    .shift     (shift),
    .busy      (busy),
    .tile_done (tile_done)
  );

  // Element for tile tag, row r, lane i: 0x00TT_RRII.
  function automatic logic [WIDTH-1:0] elem(input int tag, input int r, input int i);
    return WIDTH'((tag << 16) | (r << 8) | i);
  endfunction

  function automatic logic [LANES*WIDTH-1:0] row_word(input int tag, input int r);
    logic [LANES*WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < LANES; i++) w[i*WIDTH +: WIDTH] = elem(tag, r, i);
    return w;
  endfunction

  // Expected skewed outputs for beat c of tile tag.
  function automatic void beat_exp(input int tag, input int c,
                                   output logic [LANES*WIDTH-1:0] d,
                                   output logic [LANES-1:0] v,
                                   output logic [LANES-1:0] cl);
    d = '0; v = '0; cl = '0;
    for (int i = 0; i < LANES; i++) begin
      int r;
      r = c - i;
      if (r >= 0 && r < LANES) begin
        d[i*WIDTH +: WIDTH] = elem(tag, r, i);
        v[i] = 1'b1;
      end
      cl[i] = (r == 0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    #12;
    checks++; if (x_out !== '0) begin failures++; $display("FAIL reset_x_out: got %h want 0", x_out); end
    checks++; if (x_valid !== 8'h00) begin failures++; $display("FAIL reset_x_valid: got %h want 00", x_valid); end
    checks++; if ({start, tile_done, busy} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got start/done/busy=%b want 000", {start, tile_done, busy}); end
    checks++; if ({clear_out, shift} !== 16'h0000) begin failures++; $display("FAIL reset_clear_shift: got %h want 0000", {clear_out, shift}); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill(input int tag);
    // Enable low must refuse a presented row.
    enable = 1'b0; in_valid = 1'b1; in_data = row_word(tag, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_disabled_ready: got %b want 0", in_ready); end
    tick();
    enable = 1'b1;
    for (int r = 0; r < LANES; r++) begin
      in_data = row_word(tag, r); in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready row %0d: got %b want 1", r, in_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fill_busy row %0d: got %b want 0", r, busy); end
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_done_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fill_done_busy: got %b want 1", busy); end
  endtask

  task automatic test_issue(input int tag, input int stall_at, input int first_c);
    logic [LANES*WIDTH-1:0] ed;
    logic [LANES-1:0]       ev, ec;
`ifndef TILE_SKEW_FEEDER_PINGPONG_EN
    in_valid = 1'b1; in_data = {LANES{32'hDEAD_BEEF}};
`endif
    for (int c = first_c; c < 2*LANES-1; c++) begin
      tick();
      beat_exp(tag, c, ed, ev, ec);
      checks++; if (x_out !== ed) begin failures++; $display("FAIL issue_x_out beat %0d: got %h want %h", c, x_out, ed); end
      checks++; if (x_valid !== ev) begin failures++; $display("FAIL issue_x_valid beat %0d: got %h want %h", c, x_valid, ev); end
      checks++; if (clear_out !== ec) begin failures++; $display("FAIL issue_clear beat %0d: got %h want %h", c, clear_out, ec); end
      checks++; if ({start, shift, tile_done} !== {1'b1, 8'h00, 1'b0}) begin failures++; $display("FAIL issue_ctrl beat %0d: got start=%b shift=%h done=%b", c, start, shift, tile_done); end
`ifndef TILE_SKEW_FEEDER_PINGPONG_EN
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL issue_ready beat %0d: got %b want 0", c, in_ready); end
`endif
      if (c == 0) begin
        checks++; if ({x_out[31:0], x_valid, clear_out} !== {elem(tag, 0, 0), 8'h01, 8'h01}) begin failures++; $display("FAIL first_beat: got %h/%h/%h want %h/01/01", x_out[31:0], x_valid, clear_out, elem(tag, 0, 0)); end
      end
      if (c == 5) begin
        checks++; if (x_out[3*WIDTH +: WIDTH] !== (32'h0000_0203 | WIDTH'(tag << 16))) begin failures++; $display("FAIL beat5_lane3: got %h", x_out[3*WIDTH +: WIDTH]); end
        checks++; if (x_out[5*WIDTH +: WIDTH] !== (32'h0000_0005 | WIDTH'(tag << 16))) begin failures++; $display("FAIL beat5_lane5: got %h", x_out[5*WIDTH +: WIDTH]); end
        checks++; if (x_valid[6] !== 1'b0) begin failures++; $display("FAIL beat5_lane6_valid: got %b want 0", x_valid[6]); end
      end
      if (c == 14) begin
        checks++; if (x_valid !== 8'h80) begin failures++; $display("FAIL beat14_valid: got %h want 80", x_valid); end
        checks++; if (x_out[7*WIDTH +: WIDTH] !== (32'h0000_0707 | WIDTH'(tag << 16))) begin failures++; $display("FAIL beat14_lane7: got %h", x_out[7*WIDTH +: WIDTH]); end
      end
      if (c == stall_at) begin
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++; if ({x_out, x_valid, clear_out, start} !== {ed, ev, ec, 1'b1}) begin failures++; $display("FAIL stall_hold cycle %0d: got valid %h want %h", k, x_valid, ev); end
          checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cycle %0d: got %b want 0", k, in_ready); end
        end
        enable = 1'b1;
      end
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_drain();
    for (int k = 1; k <= DRAIN_CYC; k++) begin
      tick();
      checks++; if (shift !== 8'hFF) begin failures++; $display("FAIL drain_shift cycle %0d: got %h want ff", k, shift); end
      checks++; if ({start, x_valid, x_out} !== '0) begin failures++; $display("FAIL drain_quiet cycle %0d: start=%b valid=%h", k, start, x_valid); end
      checks++; if (tile_done !== (k == DRAIN_CYC)) begin failures++; $display("FAIL drain_done cycle %0d: got %b want %b", k, tile_done, (k == DRAIN_CYC)); end
    end
    tick();
    checks++; if ({tile_done, shift} !== 9'h000) begin failures++; $display("FAIL post_drain: got done=%b shift=%h want 0/00", tile_done, shift); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_drain_ready: got %b want 1", in_ready); end
`ifndef TILE_SKEW_FEEDER_PINGPONG_EN
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_drain_busy: got %b want 0", busy); end
`endif
  endtask

  task automatic test_async_reset();
    test_fill(3);
    test_issue(3, -1, 0);
    for (int k = 0; k < 3; k++) tick();
    #3;
    checks++; if (shift !== 8'hFF) begin failures++; $display("FAIL areset_pre_shift: got %h want ff", shift); end
    reset = 1'b0;
    #1;
    checks++; if ({shift, tile_done, start, x_valid, clear_out, busy} !== '0) begin failures++; $display("FAIL areset_outputs: shift=%h busy=%b", shift, busy); end
    checks++; if (x_out !== '0) begin failures++; $display("FAIL areset_x_out: got %h want 0", x_out); end
    tick();
    reset = 1'b1;
    tick();
    test_fill(4);
    test_issue(4, -1, 0);
    test_drain();
  endtask

`ifdef TILE_SKEW_FEEDER_PINGPONG_EN
  task automatic test_pingpong();
    for (int k = 0; k < 2*LANES; k++) begin
      in_valid = 1'b1; in_data = row_word(5 + k / LANES, k % LANES);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pp_stream_ready row %0d: got %b want 1", k, in_ready); end
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pp_both_full_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 7; k++) tick();
    checks++; if ({x_valid, x_out[7*WIDTH +: WIDTH]} !== {8'h80, elem(5, 7, 7)}) begin failures++; $display("FAIL pp_tile0_last: got %h/%h", x_valid, x_out[7*WIDTH +: WIDTH]); end
    for (int k = 1; k <= DRAIN_CYC; k++) begin
      tick();
      checks++; if ({shift, tile_done} !== {8'hFF, (k == DRAIN_CYC)}) begin failures++; $display("FAIL pp_drain cycle %0d: shift=%h done=%b", k, shift, tile_done); end
    end
    tick();
    checks++; if ({start, x_valid, clear_out, busy} !== {1'b1, 8'h01, 8'h01, 1'b1}) begin failures++; $display("FAIL pp_tile1_start: start=%b valid=%h clear=%h busy=%b", start, x_valid, clear_out, busy); end
    checks++; if (x_out[WIDTH-1:0] !== elem(6, 0, 0)) begin failures++; $display("FAIL pp_tile1_lane0: got %h want %h", x_out[WIDTH-1:0], elem(6, 0, 0)); end
    test_issue(6, -1, 1);
    test_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_fill(0);
    test_issue(0, -1, 0);
    test_drain();
    test_fill(1);
    test_issue(1, -1, 0);
    test_drain();
    test_fill(2);
    test_issue(2, 4, 0);
    test_drain();
    test_async_reset();
`ifdef TILE_SKEW_FEEDER_PINGPONG_EN
    test_pingpong();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
